clk_div_sequencer: RTL and testbench
====================================

// Module: clk_div_sequencer
// PURPOSE
//  Parametrised clock-division and run-window sequencer, successor to the free-running bench clock source.
//  From one master clk it generates NUM_CH divided clocks with one-cycle rising-edge ticks.
//  It also provides a start/run/done window with a bounded cycle counter, so CPU benches and peripherals
//  can be gated and stopped without hand-written #delays.
// PARAMETERS
//  NUM_CH  2   number of divided-clock channels
//  DIV_W   8   width of each channel's divide ratio
//  CNT_W   16  width of run limit and cycle counter
// PORTS
//  clk        in   1            master clock, all logic on rising edge
//  rst        in   1            reset, asynchronous, active-high
//  div_ratio  in   NUM_CH*DIV_W ratio per channel; ch i = [i*DIV_W +: DIV_W]; 0 = channel off
//  load       in   1            capture div_ratio into the internal ratio registers
//  run_limit  in   CNT_W        cycles per run window; 0 = unlimited; sampled on start
//  start      in   1            begin a run window (IDLE or DONE only)
//  clk_out    out  NUM_CH       divided clocks, 50% duty, period 2*ratio clk cycles
//  tick       out  NUM_CH       1-cycle pulse, high in the cycle clk_out[i] is first high
//  cycle_cnt  out  CNT_W        clk edges elapsed in the current/last window
//  running    out  1            high in RUN
//  done       out  1            high in DONE
// BEHAVIOUR
//  Reset (async, immediate):
//   - state=IDLE; ratio registers=0; all channel counters=0.
//   - clk_out=0, tick=0, cycle_cnt=0, running=0, done=0.
//   - Reset mid-run aborts the window the same way.
//  FSM IDLE/RUN/DONE; running/done are registered decodes of the state.
//   - IDLE -start-> RUN.
//   - RUN -(limit!=0 && cycle_cnt==limit-1)-> DONE.
//   - DONE -start-> RUN.
//   - start is ignored in RUN.
//  Start edge:
//   - latch run_limit; cycle_cnt<=0; channel counters<=0; clk_out<=0.
//  RUN, every edge:
//   - cycle_cnt+1; in DONE the terminal edge leaves cycle_cnt==limit.
//   - With limit 0, cycle_cnt saturates at all-ones and never wraps; the window never ends.
//  Channel i in RUN with ratio N>0:
//   - if cnt==N-1: cnt<=0, clk_out<=~clk_out, tick<=~clk_out (tick only on the 0->1 toggle).
//   - else: cnt<=cnt+1, tick<=0.
//   - First rising clk_out is N edges after the start edge; N=1 gives clk/2.
//  Ratio 0: channel held at clk_out=0, tick=0, cnt=0.
//  Outside RUN (IDLE/DONE): all channels held at cnt=0, clk_out=0, tick=0.
//   - On the RUN->DONE edge, outputs drop the same edge done rises.
//  load, accepted in any state:
//   - ratio regs<=div_ratio; every channel restarts: cnt<=0, clk_out<=0, tick<=0.
//   - Does not affect FSM or cycle_cnt.
//  load and start on the same edge: both apply; the channels start phase 0 with the new ratios.
//  load on the terminal edge: ratios update, FSM still enters DONE.
//  No combinational input-to-output paths; every output is a flop.
// TESTING
//  1. rst pulse mid-cycle while RUN -> all outputs 0 immediately (before next clk), state IDLE.
//  2. load ratios {ch1=3,ch0=1}, start, limit=0 -> ch0 toggles every edge;
//     ch1 rises 3 edges after start, period 6; tick 1 cycle per rise.
//  3. limit=10, start -> running for 10 edges; done=1, cycle_cnt=10, clk_out=0;
//     start again -> cycle_cnt restarts at 0.
//  4. load ratio ch0 2->4 at cycle 5 of RUN -> ch0 restarts low; next rise 4 edges later; cycle_cnt unaffected.
//  5. ratio 0 on ch1 -> clk_out[1]=tick[1]=0 for the whole window; ch0 unaffected.
//  6. CNT_W=4, limit=0, 20 edges -> cycle_cnt stops at 15, no wrap;
//     start during RUN ignored (no counter clear).

Source files
------------

// File: rtl/clk_div_sequencer.sv
// Clock-division and run-window sequencer: NUM_CH divided clocks with rise ticks, gated by an IDLE/RUN/DONE window.
// All outputs are flops, updating one edge after their cause; there is no handshake and inputs are never stalled.
module clk_div_sequencer #(
  parameter int NUM_CH = 2,
  parameter int DIV_W  = 8,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH*DIV_W-1:0] div_ratio,
  input  logic                    load,
  input  logic [CNT_W-1:0]        run_limit,
  input  logic                    start,
  output logic [NUM_CH-1:0]       clk_out,
  output logic [NUM_CH-1:0]       tick,
  output logic [CNT_W-1:0]        cycle_cnt,
  output logic                    running,
  output logic                    done
);

  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, DONE = 2'b10} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = 1;
  localparam logic [DIV_W-1:0] DIV_ONE = 1;

  state_t                    state, next_state;
  logic                      running_d, done_d;
  logic [CNT_W-1:0]          limit_q;
  logic [NUM_CH*DIV_W-1:0]   ratio_q;
  logic [DIV_W-1:0]          ratio_ch [NUM_CH];
  logic [DIV_W-1:0]          ch_cnt   [NUM_CH];
  logic                      start_ok;
  logic                      terminal;
  logic                      chan_run;

  assign start_ok = start && (state != RUN);
  assign terminal = (state == RUN) && (limit_q != '0) && (cycle_cnt == limit_q - CNT_ONE);
  // Channels stay cleared on the start edge, on the terminal edge and on any load edge.
  assign chan_run = (state == RUN) && (next_state == RUN) && !load;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      running <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= next_state;
      running <= running_d;
      done    <= done_d;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start)    next_state = RUN;
      RUN:     if (terminal) next_state = DONE;
      DONE:    if (start)    next_state = RUN;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    running_d = (next_state == RUN);
    done_d    = (next_state == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_cnt <= '0;
      limit_q   <= '0;
    end else if (start_ok) begin
      cycle_cnt <= '0;
      limit_q   <= run_limit;
    end else if ((state == RUN) && (cycle_cnt != '1)) begin
      cycle_cnt <= cycle_cnt + CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ratio_q <= '0;
    end else if (load) begin
      ratio_q <= div_ratio;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      ratio_ch[i] = ratio_q[i*DIV_W +: DIV_W];
    end
  end

  // tick takes the pre-toggle inverse so it fires only on the low-to-high toggle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        ch_cnt[i] <= '0;
      end
      clk_out <= '0;
      tick    <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (!chan_run || (ratio_ch[i] == '0)) begin
          ch_cnt[i]  <= '0;
          clk_out[i] <= 1'b0;
          tick[i]    <= 1'b0;
        end else if (ch_cnt[i] == ratio_ch[i] - DIV_ONE) begin
          ch_cnt[i]  <= '0;
          clk_out[i] <= ~clk_out[i];
          tick[i]    <= ~clk_out[i];
        end else begin
          ch_cnt[i]  <= ch_cnt[i] + DIV_ONE;
          tick[i]    <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_clk_div_sequencer.sv
// Directed plus randomized bench for clk_div_sequencer; a second instance with a 4-bit counter covers saturation.
module tb_clk_div_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] div_ratio = '0;
  logic        load = 1'b0;
  logic [15:0] run_limit = '0;
  logic        start = 1'b0;

  logic [1:0]  clk_out, tick;
  logic [15:0] cycle_cnt;
  logic        running, done;

  logic [1:0]  s_clk_out, s_tick;
  logic [3:0]  s_cycle_cnt;
  logic        s_running, s_done;

  clk_div_sequencer #(.NUM_CH(2), .DIV_W(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .div_ratio(div_ratio), .load(load), .run_limit(run_limit),
    .start(start), .clk_out(clk_out), .tick(tick), .cycle_cnt(cycle_cnt),
    .running(running), .done(done)
  );

  clk_div_sequencer #(.NUM_CH(2), .DIV_W(8), .CNT_W(4)) dut_small (
    .clk(clk), .rst(rst), .div_ratio(div_ratio), .load(load), .run_limit(run_limit[3:0]),
    .start(start), .clk_out(s_clk_out), .tick(s_tick), .cycle_cnt(s_cycle_cnt),
    .running(s_running), .done(s_done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: absolute edge numbers of the last start and last load.
  int t = 0;
  int s = 0;
  int lim_m = 0;
  int load_t = -1;
  bit win = 1'b0;
  int rat [2] = '{0, 0};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int v, input int cap);
    return (v > cap) ? cap : v;
  endfunction

  task automatic check_all(input string tag);
    int k, o, kk, ec, es;
    bit run_a, done_a;
    logic [1:0] eclk, etick;
    run_a = 1'b0; done_a = 1'b0; ec = 0; es = 0;
    eclk = '0; etick = '0;
    if (win) begin
      k      = t - s;
      run_a  = (lim_m == 0) || (k < lim_m);
      done_a = !run_a;
      ec     = (lim_m == 0) ? sat(k, 65535) : sat(k, lim_m);
      es     = (lim_m == 0) ? sat(k, 15)    : sat(k, lim_m);
    end
    if (run_a) begin
      o  = (load_t > s) ? load_t : s;
      kk = t - o;
      for (int i = 0; i < 2; i++) begin
        if (rat[i] > 0) begin
          eclk[i]  = ((kk / rat[i]) % 2) == 1;
          etick[i] = eclk[i] && ((kk % rat[i]) == 0);
        end
      end
    end
    chk({tag, ".running"},   running,     run_a);
    chk({tag, ".done"},      done,        done_a);
    chk({tag, ".cycle_cnt"}, cycle_cnt,   ec);
    chk({tag, ".clk_out"},   clk_out,     eclk);
    chk({tag, ".tick"},      tick,        etick);
    chk({tag, ".s_cnt"},     s_cycle_cnt, es);
    chk({tag, ".s_running"}, s_running,   run_a);
    chk({tag, ".s_clk_out"}, s_clk_out,   eclk);
  endtask

  task automatic step(input string tag, input bit ld, input bit st,
                      input logic [15:0] ratio, input logic [15:0] lim);
    bit run_before;
    div_ratio = ratio;
    load      = ld;
    start     = st;
    run_limit = lim;
    @(posedge clk);
    run_before = win && ((lim_m == 0) || ((t - s) < lim_m));
    t++;
    if (ld) begin
      load_t = t;
      rat[0] = int'(ratio[7:0]);
      rat[1] = int'(ratio[15:8]);
    end
    if (st && !run_before) begin
      win   = 1'b1;
      s     = t;
      lim_m = int'(lim);
    end
    #1;
    check_all(tag);
    load  = 1'b0;
    start = 1'b0;
  endtask

  // Reset lands between edges; outputs must clear before the next rising edge.
  task automatic mid_reset(input string tag);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk({tag, ".running"},   running,     1'b0);
    chk({tag, ".done"},      done,        1'b0);
    chk({tag, ".cycle_cnt"}, cycle_cnt,   16'd0);
    chk({tag, ".clk_out"},   clk_out,     2'b00);
    chk({tag, ".tick"},      tick,        2'b00);
    chk({tag, ".s_cnt"},     s_cycle_cnt, 4'd0);
    @(posedge clk);
    @(negedge clk);
    rst    = 1'b0;
    win    = 1'b0;
    load_t = -1;
    rat[0] = 0;
    rat[1] = 0;
  endtask

  initial begin
    #12;
    chk("reset.running",   running,   1'b0);
    chk("reset.done",      done,      1'b0);
    chk("reset.cycle_cnt", cycle_cnt, 16'd0);
    chk("reset.clk_out",   clk_out,   2'b00);
    chk("reset.tick",      tick,      2'b00);
    @(negedge clk);
    rst = 1'b0;
    step("idle", 0, 0, 16'h0000, 16'd0);

    // ch1=3, ch0=1, unlimited window; load and start on the same edge.
    step("div_start", 1, 1, 16'h0301, 16'd0);
    for (int i = 0; i < 22; i++) begin
      step("div_run", 0, (i == 12), 16'h0000, 16'd0);
    end

    mid_reset("rst_mid_run");
    step("after_rst", 0, 0, 16'h0000, 16'd0);

    // Bounded window of 10 edges, then restart from DONE.
    step("lim_load", 1, 0, 16'h0201, 16'd0);
    step("lim_start", 0, 1, 16'h0000, 16'd10);
    for (int i = 0; i < 14; i++) begin
      step("lim_run", 0, 0, 16'h0000, 16'd0);
    end
    step("lim_restart", 0, 1, 16'h0000, 16'd10);
    for (int i = 0; i < 12; i++) begin
      step("lim_rerun", 0, 0, 16'h0000, 16'd0);
    end

    // Load on the terminal edge of a 3-edge window.
    step("term_start", 0, 1, 16'h0000, 16'd3);
    step("term_run", 0, 0, 16'h0000, 16'd0);
    step("term_run", 0, 0, 16'h0000, 16'd0);
    step("term_load", 1, 0, 16'h0102, 16'd0);
    for (int i = 0; i < 3; i++) begin
      step("term_done", 0, 0, 16'h0000, 16'd0);
    end

    // ch0 ratio 2 -> 4 mid-run, ch1 off throughout.
    step("reload_start", 1, 1, 16'h0002, 16'd0);
    for (int i = 0; i < 4; i++) begin
      step("reload_pre", 0, 0, 16'h0000, 16'd0);
    end
    step("reload_load", 1, 0, 16'h0004, 16'd0);
    for (int i = 0; i < 12; i++) begin
      step("reload_post", 0, 0, 16'h0000, 16'd0);
    end

    mid_reset("rst_pre_rand");
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 79) == 0) begin
        mid_reset("rand_rst");
      end else begin
        step("rand",
             ($urandom_range(0, 7) == 0),
             ($urandom_range(0, 5) == 0),
             {8'($urandom_range(0, 5)), 8'($urandom_range(0, 5))},
             16'($urandom_range(0, 15)));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
